// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared constants, FSM state type and the letter-code to ASCII
//               conversion used by the cipher transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

  localparam int              LETTER_W    = 6;
  localparam logic [LETTER_W-1:0] CODE_SPACE = 6'd26;
  localparam logic [7:0]      ASCII_A     = 8'h41;
  localparam logic [7:0]      ASCII_SPACE = 8'h20;
  localparam logic [7:0]      ASCII_UNK   = 8'h3F;

  // UART transmitter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Letters map onto 'A'..'Z', code 26 is a space, anything else prints as '?'
  function automatic logic [7:0] letter_to_ascii(input logic [LETTER_W-1:0] code);
    logic [7:0] r;
    if (code < CODE_SPACE) begin
      r = ASCII_A + {2'b00, code};
    end else if (code == CODE_SPACE) begin
      r = ASCII_SPACE;
    end else begin
      r = ASCII_UNK;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_uart_tx_letter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : letter_fifo
// Description : Small synchronous FIFO buffering letter codes ahead of the
//               UART transmitter. Head entry is visible combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module letter_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks net change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/enigma_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : enigma_uart_tx
// Description : Buffers 6-bit lampboard letter codes, converts each to ASCII
//               and sends it as a UART 8N1 frame on a registered serial pin.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_uart_tx
  import enigma_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 9600,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LETTER_W-1:0]           letter_in,
  input  logic                          letter_valid,
  output logic                          letter_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);

  localparam int               CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int               CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t          r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [2:0]         r_bit_idx, w_bit_next, w_bit_inc;
  logic [7:0]         r_shift, w_shift_next;
  logic               r_tx, w_tx_next;
  logic               r_frame_done, w_frame_done_next;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [LETTER_W-1:0] w_head;

  assign w_push       = letter_valid && letter_ready;
  assign letter_ready = !w_full;
  assign busy         = (r_state != ST_IDLE) || (fifo_count != '0);
  assign tx           = r_tx;
  assign frame_done   = r_frame_done;
  assign w_bit_inc    = r_bit_idx + 3'd1;

  letter_fifo #(
    .WIDTH (LETTER_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (letter_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // State register; tx resets high so an aborted frame releases the line at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit_idx    <= w_bit_next;
      r_shift      <= w_shift_next;
      r_tx         <= w_tx_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  // Next-state logic; tx is computed for the upcoming cycle so the pin is a flop
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_bit_next        = r_bit_idx;
    w_shift_next      = r_shift;
    w_tx_next         = 1'b1;
    w_frame_done_next = 1'b0;
    w_pop             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = letter_to_ascii(w_head);
          w_cnt_next   = '0;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        w_tx_next = 1'b0;
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_bit_next   = 3'd0;
          w_state_next = ST_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        w_tx_next = r_shift[r_bit_idx];
        if (r_cnt == CNT_LAST) begin
          w_cnt_next = '0;
          // bit index wraps 7->0 exactly as the frame leaves the data phase
          w_bit_next = w_bit_inc;
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_tx_next = r_shift[w_bit_inc];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        w_tx_next = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_next        = '0;
          w_frame_done_next = 1'b1;
          w_state_next      = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_enigma_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_uart_tx
// Description : Self-checking bench for enigma_uart_tx with 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enigma_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] letter_in;
  logic       letter_valid;
  logic       letter_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       frame_done;

  int n_cmp   = 0;
  int n_err   = 0;
  int fd_hits = 0;

  typedef struct {
    logic [5:0] code;
    logic [7:0] ascii;
  } vec_t;

  vec_t vecs [6];

  enigma_uart_tx #(
    .CLK_FREQ_HZ (16),
    .BAUD        (1),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .letter_in    (letter_in),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .frame_done   (frame_done)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Hang guard
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n falling edges, counting frame_done pulses seen
  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_hits++;
    end
  endtask

  // Receive one frame sampling mid-bit; ends on the first idle cycle after stop
  task automatic rx_frame(input string tag, input logic [7:0] exp_byte, input int exp_waits);
    int         waits;
    logic [7:0] b;
    waits = 0;
    while (tx !== 1'b0 && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (tx !== 1'b0) begin
      check({tag, " start timeout tx"}, tx, 1'b0);
      return;
    end
    if (exp_waits >= 0) check({tag, " idle gap"}, waits, exp_waits);
    fd_hits = 0;
    step(7);
    check({tag, " start bit"}, tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(16);
      b[i] = tx;
    end
    check({tag, " byte"}, b, exp_byte);
    step(16);
    check({tag, " stop bit"}, tx, 1'b1);
    step(8);
    check({tag, " frame_done early"}, frame_done, 1'b0);
    step(1);
    check({tag, " frame_done at 160"}, frame_done, 1'b1);
    check({tag, " frame_done pulses"}, fd_hits, 1);
    check({tag, " idle tx"}, tx, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   peak;
    int   guard;
    int   bad;
    logic acc;
    logic dropped;

    vecs[0] = '{6'd0,  8'h41};
    vecs[1] = '{6'd25, 8'h5A};
    vecs[2] = '{6'd26, 8'h20};
    vecs[3] = '{6'd40, 8'h3F};
    vecs[4] = '{6'd63, 8'h3F};
    vecs[5] = '{6'd12, 8'h4D};

    letter_in    = '0;
    letter_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst ready", letter_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst count", fifo_count, 4'd0);
    check("rst frame_done", frame_done, 1'b0);
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      check("idle tx", tx, 1'b1);
      check("idle ready", letter_ready, 1'b1);
      check("idle busy", busy, 1'b0);
      check("idle count", fifo_count, 4'd0);
    end

    // Single letter: tx falls two edges after the write
    letter_in    = 6'd0;
    letter_valid = 1'b1;
    @(negedge clk);
    letter_valid = 1'b0;
    check("single pre tx", tx, 1'b1);
    check("single pre count", fifo_count, 4'd1);
    check("single pre busy", busy, 1'b1);
    rx_frame("single", 8'h41, 1);
    repeat (5) @(negedge clk);

    // Mapping table, back-to-back frames with one idle cycle between
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          letter_in    = vecs[i].code;
          letter_valid = 1'b1;
          @(negedge clk);
        end
        letter_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_frame($sformatf("map%0d", i), vecs[i].ascii, (i == 0) ? 2 : 1);
        end
      end
    join
    check("map end busy", busy, 1'b0);

    // Backpressure from reset: codes 0..9 with valid held
    do_reset();
    peak    = 0;
    dropped = 1'b0;
    guard   = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          letter_in    = 6'(i);
          letter_valid = 1'b1;
          do begin
            acc = letter_ready;
            if (!acc) dropped = 1'b1;
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            guard++;
          end while (!acc && guard < 5000);
        end
        letter_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          rx_frame($sformatf("bp%0d", i), 8'h41 + 8'(i), (i == 0) ? 2 : 1);
        end
      end
    join
    check("bp guard expired", guard >= 5000, 1'b0);
    check("bp peak count", peak, 8);
    check("bp ready dropped", dropped, 1'b1);
    check("bp end count", fifo_count, 4'd0);

    // Simultaneous push and pop of the last entry
    letter_in    = 6'd2;
    letter_valid = 1'b1;
    @(negedge clk);
    letter_in    = 6'd3;
    @(negedge clk);
    letter_valid = 1'b0;
    check("simul pre count", fifo_count, 4'd1);
    rx_frame("simA", 8'h43, 0);
    check("simul idle count", fifo_count, 4'd1);
    letter_in    = 6'd4;
    letter_valid = 1'b1;
    @(negedge clk);
    letter_valid = 1'b0;
    check("simul count", fifo_count, 4'd1);
    check("simul tx started", tx, 1'b0);
    rx_frame("simB", 8'h44, 0);
    rx_frame("simC", 8'h45, 1);

    // Reset during DATA bit 3 with three letters buffered
    for (int i = 0; i < 4; i++) begin
      letter_in    = 6'd0;
      letter_valid = 1'b1;
      @(negedge clk);
    end
    letter_valid = 1'b0;
    check("abort buffered", fifo_count, 4'd3);
    repeat (69) @(negedge clk);
    check("abort bit3 tx", tx, 1'b0);
    check("abort pre count", fifo_count, 4'd3);
    #2;
    rst = 1'b1;
    #1;
    check("abort async tx", tx, 1'b1);
    check("abort count", fifo_count, 4'd0);
    check("abort busy", busy, 1'b0);
    check("abort ready", letter_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("post abort quiet cycles", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enigma_uart_tx.md
Name: enigma_uart_tx

Overview:
Transmit end of the cipher path. Accepts 6-bit letter codes from the enciphering core's lampboard output and buffers them in a small FIFO. Each code is converted to ASCII and shipped as UART 8N1 frames on a single serial pin to the host terminal. It is the transmitter counterpart to the keyboard/receive side that feeds letter codes into the core.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide, must be >= 2)
FIFO_DEPTH, 8, letter buffer entries (power of two, >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
letter_in  input  6  letter code; 0..25 = A..Z, 26 = space, 27..63 = invalid
letter_valid  input  1  letter_in is presented this cycle
letter_ready  output  1  FIFO can accept; transfer occurs when valid && ready
tx  output  1  UART serial out, idle high
busy  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently buffered
frame_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (async assert, sync-released by clk): tx=1, letter_ready=1, busy=0, fifo_count=0, frame_done=0, FSM=IDLE, counters=0, FIFO pointers=0. Asserting rst mid-frame aborts the frame and drives tx high immediately. Buffered letters are discarded.
- Handshake: letter_ready = (fifo_count != FIFO_DEPTH). A write happens on a clock edge where letter_valid && letter_ready. No write occurs when the FIFO is full; the producer holds its data.
- Simultaneous write and pop on the same edge: allowed in every state, including full (ready is low when full, so no write then) and empty-with-write (no pop, since the FIFO is empty). fifo_count changes by +1, -1 or 0 accordingly.
- ASCII map, applied at pop: code c in 0..25 -> 8'h41+c; 26 -> 8'h20; 27..63 -> 8'h3F ('?').
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head, latch its ASCII byte into shift_reg, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, pulse frame_done and go to IDLE.
- Latency: a write into an empty FIFO while in IDLE produces the tx falling edge 2 cycles later (one cycle to write, one cycle to pop). Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: IDLE lasts one cycle between frames, so the inter-frame gap is 1 clk of idle-high beyond the stop bit.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps; bit_idx is 3 bits and wraps 7->0 only on the DATA->STOP transition.
- busy = (FSM != IDLE) || (fifo_count != 0).
- tx is registered (glitch-free output).

Decomposition:
- Shared package enigma_pkg: LETTER_W=6, CODE_SPACE=6'd26, ASCII_A=8'h41, ASCII_SPACE=8'h20, ASCII_UNK=8'h3F, the FSM state enum, and a letter_to_ascii function.
- One sub-module: letter_fifo (synchronous FIFO).
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/full/empty/count, same async active-high rst.
- The UART FSM and baud counter stay in enigma_uart_tx.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=16, BAUD=1 (CLKS_PER_BIT=16).
- Reset then idle: hold rst 3 cycles, release -> tx=1, letter_ready=1, busy=0, fifo_count=0 for 200 cycles.
- Single letter: write code 0 -> tx low at write+2. Sampling mid-bit recovers 8'h41, LSB first (1,0,0,0,0,0,1,0). Stop bit high. frame_done pulses once, 160 cycles after the start edge.
- Mapping: write codes 25, 26, 40 -> frames carry 8'h5A, 8'h20, 8'h3F in order, each separated by exactly 1 idle cycle.
- Full/backpressure: hold valid with codes 0..9 from reset. letter_ready drops after the FIFO fills; fifo_count peaks at 8 (one entry already popped into the first frame, so 9 accepted before stall). Remaining codes are accepted as frames complete. All 10 frames appear in order with no loss or duplication.
- Simultaneous push/pop: write a new code on the exact cycle IDLE pops the last entry -> fifo_count ends at 1 and the next frame carries the new letter.
- Reset mid-operation: assert rst during DATA bit 3 with 3 letters buffered -> tx=1 in the same cycle (async), fifo_count=0, busy=0. After release, no further frames.
